// File: rtl/shift_ram_pkg.sv
// Shared definitions for the shift-register RAM buffer: default sizes and the
// push/pop operation encoding used by the top and the occupancy tracker.
package shift_ram_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned DEPTH_DEF      = 8;

  typedef enum logic [1:0] {
    OP_NONE     = 2'b00,
    OP_PUSH     = 2'b01,
    OP_POP      = 2'b10,
    OP_PUSH_POP = 2'b11
  } op_e;

  // Encoding is chosen so {pop, push} maps directly onto the enum.
  function automatic op_e decode_op(input logic push, input logic pop);
    return op_e'({pop, push});
  endfunction

endpackage

// File: rtl/shift_ram_buf_if.sv
// Bus bundle for shift_ram_buf.
//   master: producer/consumer side (drives en/push/pop/din/addr[/clr])
//   slave : buffer side (drives read, pop, occupancy and pulse outputs)
// Optional clr input exists only when SHIFT_RAM_BUF_CLR_EN is defined.
interface shift_ram_buf_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8
);
  localparam int unsigned AW = $clog2(DEPTH);

`ifdef SHIFT_RAM_BUF_CLR_EN
  logic                  clr;
`endif
  logic                  en;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] din;
  logic [AW-1:0]         addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_hit;
  logic [DATA_WIDTH-1:0] pop_data;
  logic                  pop_valid;
  logic [AW:0]           count;
  logic                  full;
  logic                  empty;
  logic                  overflow;
  logic                  underflow;

  modport master (
`ifdef SHIFT_RAM_BUF_CLR_EN
    output clr,
`endif
    output en, push, pop, din, addr,
    input  rd_data, rd_hit, pop_data, pop_valid, count, full, empty,
           overflow, underflow
  );

  modport slave (
`ifdef SHIFT_RAM_BUF_CLR_EN
    input  clr,
`endif
    input  en, push, pop, din, addr,
    output rd_data, rd_hit, pop_data, pop_valid, count, full, empty,
           overflow, underflow
  );

endinterface

// File: rtl/shift_ram_buf_occ.sv
// Occupancy tracker for shift_ram_buf: owns count and derives full/empty
// plus the registered overflow/underflow pulses.
// Ports: clock, reset (sync, active-high), en_i, clr_i, op_i,
//        count_o, full_o, empty_o (comb from count), overflow_o, underflow_o.
module shift_ram_occ
  import shift_ram_pkg::*;
#(
  parameter  int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en_i,
  input  logic        clr_i,
  input  op_e         op_i,
  output logic [AW:0] count_o,
  output logic        full_o,
  output logic        empty_o,
  output logic        overflow_o,
  output logic        underflow_o
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  logic [AW:0] count_q, count_d;
  logic        ovf_q, ovf_d;
  logic        udf_q, udf_d;

  // Next count and pulses; push+pop at nonzero count is a pure replacement.
  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    udf_d   = 1'b0;
    if (en_i) begin
      if (clr_i) begin
        count_d = '0;
      end else begin
        case (op_i)
          OP_PUSH: begin
            if (count_q == DEPTH_C) ovf_d   = 1'b1;
            else                    count_d = count_q + ONE_C;
          end
          OP_POP: begin
            if (count_q == '0) udf_d   = 1'b1;
            else               count_d = count_q - ONE_C;
          end
          OP_PUSH_POP: begin
            if (count_q == '0) begin
              udf_d   = 1'b1;
              count_d = ONE_C;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign count_o     = count_q;
  assign full_o      = (count_q == DEPTH_C);
  assign empty_o     = (count_q == '0);
  assign overflow_o  = ovf_q;
  assign underflow_o = udf_q;

endmodule

// File: rtl/shift_ram_buf.sv
// Shift-register RAM buffer: pushes shift every entry up one slot and write
// slot 0 (newest); pops drain the oldest valid entry; a registered indexed
// read port returns any slot with a hit flag for valid entries.
// Ports: clock, reset (sync, active-high), bus (shift_ram_buf_if.slave).
// Optional: SHIFT_RAM_BUF_CLR_EN adds bus.clr, a synchronous clear of
// entries and count that leaves rd_data/pop_data untouched.
module shift_ram_buf
  import shift_ram_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int unsigned DEPTH      = DEPTH_DEF,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic           clock,
  input  logic           reset,
  shift_ram_buf_if.slave bus
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  typedef logic [DATA_WIDTH-1:0] data_t;

  data_t       mem_q [DEPTH];
  data_t       mem_d [DEPTH];
  data_t       rd_data_q, rd_data_d;
  logic        rd_hit_q, rd_hit_d;
  data_t       pop_data_q, pop_data_d;
  logic        pop_valid_q, pop_valid_d;
  logic [AW:0] count_c;
  logic        clr_c;
  op_e         op_c;

`ifdef SHIFT_RAM_BUF_CLR_EN
  assign clr_c = bus.clr;
`else
  assign clr_c = 1'b0;
`endif

  assign op_c = decode_op(bus.push, bus.pop);

  shift_ram_occ #(
    .DEPTH (DEPTH)
  ) u_occ (
    .clock       (clock),
    .reset       (reset),
    .en_i        (bus.en),
    .clr_i       (clr_c),
    .op_i        (op_c),
    .count_o     (count_c),
    .full_o      (bus.full),
    .empty_o     (bus.empty),
    .overflow_o  (bus.overflow),
    .underflow_o (bus.underflow)
  );

  // Storage, read port and pop datapath; all reads see pre-edge contents.
  always_comb begin
    mem_d       = mem_q;
    rd_data_d   = rd_data_q;
    rd_hit_d    = rd_hit_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    if (bus.en) begin
      if (clr_c) begin
        for (int i = 0; i < int'(DEPTH); i++) mem_d[i] = '0;
      end else begin
        // Addresses past DEPTH only exist when DEPTH is not a power of two.
        if ((AW+1)'(bus.addr) < DEPTH_C) begin
          rd_data_d = mem_q[bus.addr];
          rd_hit_d  = ((AW+1)'(bus.addr) < count_c);
        end else begin
          rd_data_d = '0;
          rd_hit_d  = 1'b0;
        end
        if ((op_c == OP_POP || op_c == OP_PUSH_POP) && count_c != '0) begin
          pop_data_d  = mem_q[AW'(count_c - ONE_C)];
          pop_valid_d = 1'b1;
        end
        if (op_c == OP_PUSH || op_c == OP_PUSH_POP) begin
          for (int i = int'(DEPTH) - 1; i > 0; i--) mem_d[i] = mem_q[i-1];
          mem_d[0] = bus.din;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q       <= '{default: '0};
      rd_data_q   <= '0;
      rd_hit_q    <= 1'b0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      rd_data_q   <= rd_data_d;
      rd_hit_q    <= rd_hit_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_hit    = rd_hit_q;
  assign bus.pop_data  = pop_data_q;
  assign bus.pop_valid = pop_valid_q;
  assign bus.count     = count_c;

endmodule

// File: tb/tb_shift_ram_buf.sv
// Directed bench for shift_ram_buf (DATA_WIDTH=8, DEPTH=8): inputs change
// 1 time unit after a rising edge, outputs are checked at the same point.
module tb_shift_ram_buf;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  shift_ram_buf_if #(.DATA_WIDTH(8), .DEPTH(8)) bus ();

  shift_ram_buf #(.DATA_WIDTH(8), .DEPTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
`ifdef SHIFT_RAM_BUF_CLR_EN
    bus.clr = 1'b0;
`endif
    bus.en   = 1'b0;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    bus.din  = 8'h00;
    bus.addr = 3'd0;
    step();
    step();

    // Reset state
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_pop_valid", 32'(bus.pop_valid), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_udf", 32'(bus.underflow), 32'd0);

    // Read addr 3 on an empty buffer
    reset    = 1'b0;
    bus.en   = 1'b1;
    bus.addr = 3'd3;
    step();
    chk("empty_rd_data", 32'(bus.rd_data), 32'h00);
    chk("empty_rd_hit", 32'(bus.rd_hit), 32'd0);
    chk("empty_count", 32'(bus.count), 32'd0);

    // Reset mid-fill
    bus.push = 1'b1;
    bus.din  = 8'h01;
    step();
    bus.din  = 8'h02;
    step();
    chk("midfill_count", 32'(bus.count), 32'd2);
    reset = 1'b1;
    step();
    chk("midfill_rst_count", 32'(bus.count), 32'd0);
    chk("midfill_rst_empty", 32'(bus.empty), 32'd1);
    reset = 1'b0;

    // Fill with 0x11..0x88
    for (int i = 1; i <= 8; i++) begin
      bus.din = 8'(i * 8'h11);
      step();
    end
    chk("fill_count", 32'(bus.count), 32'd8);
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_ovf", 32'(bus.overflow), 32'd0);
    bus.push = 1'b0;
    bus.addr = 3'd0;
    step();
    chk("rd0_data", 32'(bus.rd_data), 32'h88);
    chk("rd0_hit", 32'(bus.rd_hit), 32'd1);
    bus.addr = 3'd7;
    step();
    chk("rd7_data", 32'(bus.rd_data), 32'h11);
    chk("rd7_hit", 32'(bus.rd_hit), 32'd1);

    // Ninth push overflows; coincident read sees old contents
    bus.push = 1'b1;
    bus.din  = 8'h99;
    step();
    chk("ovf_pulse", 32'(bus.overflow), 32'd1);
    chk("ovf_count", 32'(bus.count), 32'd8);
    chk("ovf_rd_old", 32'(bus.rd_data), 32'h11);
    bus.push = 1'b0;
    step();
    chk("ovf_pulse_end", 32'(bus.overflow), 32'd0);
    chk("ovf_rd7_new", 32'(bus.rd_data), 32'h22);

    // Pop at full
    bus.pop = 1'b1;
    step();
    chk("pop_data", 32'(bus.pop_data), 32'h22);
    chk("pop_valid", 32'(bus.pop_valid), 32'd1);
    chk("pop_count", 32'(bus.count), 32'd7);
    chk("pop_full", 32'(bus.full), 32'd0);
    bus.pop = 1'b0;
    step();
    chk("pop_valid_end", 32'(bus.pop_valid), 32'd0);
    chk("pop_rd7_stale", 32'(bus.rd_data), 32'h22);
    chk("pop_rd7_miss", 32'(bus.rd_hit), 32'd0);

    // Push + pop at count 7
    bus.push = 1'b1;
    bus.pop  = 1'b1;
    bus.din  = 8'hAA;
    step();
    chk("pp7_pop_data", 32'(bus.pop_data), 32'h33);
    chk("pp7_pop_valid", 32'(bus.pop_valid), 32'd1);
    chk("pp7_count", 32'(bus.count), 32'd7);
    chk("pp7_ovf", 32'(bus.overflow), 32'd0);

    // Refill to 8, then push + pop at full
    bus.pop = 1'b0;
    bus.din = 8'hCC;
    step();
    chk("refill_count", 32'(bus.count), 32'd8);
    bus.pop = 1'b1;
    bus.din = 8'hBB;
    step();
    chk("ppfull_pop_data", 32'(bus.pop_data), 32'h44);
    chk("ppfull_count", 32'(bus.count), 32'd8);
    chk("ppfull_ovf", 32'(bus.overflow), 32'd0);
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    bus.addr = 3'd0;
    step();
    chk("ppfull_rd0", 32'(bus.rd_data), 32'hBB);

    // Underflow cases from empty
    reset = 1'b1;
    step();
    reset   = 1'b0;
    bus.pop = 1'b1;
    step();
    chk("udf_pulse", 32'(bus.underflow), 32'd1);
    chk("udf_pop_valid", 32'(bus.pop_valid), 32'd0);
    chk("udf_pop_data", 32'(bus.pop_data), 32'h00);
    chk("udf_count", 32'(bus.count), 32'd0);
    bus.push = 1'b1;
    bus.din  = 8'h5A;
    step();
    chk("udfpp_count", 32'(bus.count), 32'd1);
    chk("udfpp_udf", 32'(bus.underflow), 32'd1);
    chk("udfpp_pop_valid", 32'(bus.pop_valid), 32'd0);
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    step();
    chk("udfpp_udf_end", 32'(bus.underflow), 32'd0);
    chk("udfpp_rd0", 32'(bus.rd_data), 32'h5A);
    chk("udfpp_rd0_hit", 32'(bus.rd_hit), 32'd1);

    // en = 0 holds everything and suppresses pulses
    bus.en   = 1'b0;
    bus.push = 1'b1;
    bus.pop  = 1'b1;
    bus.din  = 8'h77;
    bus.addr = 3'd1;
    step();
    step();
    chk("en0_count", 32'(bus.count), 32'd1);
    chk("en0_rd_data", 32'(bus.rd_data), 32'h5A);
    chk("en0_rd_hit", 32'(bus.rd_hit), 32'd1);
    chk("en0_pop_valid", 32'(bus.pop_valid), 32'd0);
    chk("en0_udf", 32'(bus.underflow), 32'd0);
    bus.en   = 1'b1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    step();
    chk("en1_rd1_data", 32'(bus.rd_data), 32'h00);
    chk("en1_rd1_hit", 32'(bus.rd_hit), 32'd0);
    chk("en1_count", 32'(bus.count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_ram_buf.md
Name: shift_ram_buf

Overview:
- Parametrised shift-register RAM: each push shifts all entries up one slot and writes new data into slot 0 (newest).
- Adds occupancy tracking, full/empty flags, pop of the oldest entry, and overflow/underflow pulses.
- Adds a registered random-access read port with a hit flag.
- Sits between a sample producer and consumers that need both indexed history access and in-order drain.

Parameters:
- DATA_WIDTH, 8, width of each entry in bits.
- DEPTH, 8, number of entries; legal range is DEPTH >= 2.
- AW, $clog2(DEPTH), address and count field width (derived, not overridden).

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  global enable; when 0 all state holds.
- push  input  1  shift din into slot 0.
- pop  input  1  remove the oldest valid entry.
- din  input  DATA_WIDTH  push data.
- addr  input  AW  read address; 0 is newest.
- rd_data  output  DATA_WIDTH  registered read data.
- rd_hit  output  1  registered; 1 when addr held a valid entry.
- pop_data  output  DATA_WIDTH  registered popped data.
- pop_valid  output  1  one-cycle pulse, pop_data valid.
- count  output  AW+1  number of valid entries, 0..DEPTH.
- full  output  1  count == DEPTH (combinational from count).
- empty  output  1  count == 0 (combinational from count).
- overflow  output  1  one-cycle pulse, oldest entry lost.
- underflow  output  1  one-cycle pulse, pop while empty.

Behaviour:
- Reset (synchronous, priority over everything):
  - All entries, count, rd_data, pop_data = 0.
  - rd_hit, pop_valid, overflow, underflow = 0.
  - Consequently full = 0, empty = 1.
- en = 0:
  - Entries, count, rd_data, rd_hit, pop_data hold.
  - pop_valid, overflow, underflow = 0.
- All operations below apply with en = 1 and sample pre-edge state.
- Read, every enabled cycle, latency 1:
  - rd_data <= mem[addr]; rd_hit <= (addr < count).
  - addr >= DEPTH (non-power-of-2 DEPTH): rd_data <= 0, rd_hit <= 0.
  - A read coincident with a push returns old contents.
- push only:
  - mem[i] <= mem[i-1] for i = 1..DEPTH-1; mem[0] <= din.
  - count < DEPTH: count + 1.
  - count == DEPTH: count holds, overflow = 1, old mem[DEPTH-1] discarded.
- pop only:
  - count > 0: pop_data <= mem[count-1], pop_valid = 1, count - 1. The vacated entry is not cleared.
  - count == 0: underflow = 1, pop_valid = 0, pop_data holds.
- push and pop together:
  - count > 0: pop_data <= mem[count-1] (pre-shift), pop_valid = 1, shift-in proceeds, count unchanged, no overflow even when full.
  - count == 0: pop is ignored (underflow = 1); push proceeds; count = 1.
- Neither push nor pop: entries and count hold; pulses = 0.
- count arithmetic is in AW+1 bits and never wraps.

Optional Feature:
- Macro: SHIFT_RAM_BUF_CLR_EN.
- Defined: adds input port clr (1 bit). When clr = 1 and en = 1:
  - count = 0, all entries = 0, pulses = 0.
  - rd_data and pop_data hold.
  - clr has priority over push/pop; reset still has priority over clr.
- Undefined: no clr port; the only clear is reset.

Decomposition:
- Package shift_ram_pkg:
  - DATA_WIDTH_DEF = 8 and DEPTH_DEF = 8.
  - Typedef for the op encoding {NONE, PUSH, POP, PUSH_POP}, decoded from push/pop.
- One sub-module, shift_ram_occ:
  - Owns count, full, empty, overflow and underflow from push/pop/en/clr.
  - The top module holds the storage array and the read/pop datapaths.

Test Plan:
- Reset, then addr = 3 for one cycle -> rd_data = 0x00, rd_hit = 0, count = 0, empty = 1; assert reset mid-fill -> count = 0 on the next edge.
- Push 0x11..0x88 (8 cycles) -> count = 8, full = 1; addr = 0 reads 0x88, addr = 7 reads 0x11, rd_hit = 1.
- Ninth push of 0x99 -> overflow = 1 for one cycle, count = 8; addr = 7 now reads 0x22.
- Pop at full -> pop_data = 0x22, pop_valid = 1 for one cycle, count = 7; next, push + pop with din 0xAA -> pop_data = 0x33, count = 7, overflow = 0.
- Push + pop at full with din 0xBB -> count stays 8, overflow = 0, the oldest entry appears on pop_data.
- Pop with count = 0 -> underflow = 1, pop_valid = 0. Push 0x5A + pop with count = 0 -> count = 1, underflow = 1, addr = 0 reads 0x5A. Holding en = 0 with push = 1 -> no state change.
